// File: rtl/alu_issue_if.sv
// Purpose: bundles the request, ALU-drive and writeback signals of alu_issue_ctrl.
// Ports (slave = controller view):
//   flush_i                         kill all pending work
//   req{0,1}_valid_i/ready_o        requester handshakes, with op/a/b/tid payload
//   alu_op_o/alu_a_o/alu_b_o        operation and operands to the ALU
//   alu_result_i/alu_branch_i       registered ALU outputs
//   wb_valid_o/wb_ready_i           result FIFO head handshake, with result/branch/tid/src
//   busy_o                          work in flight or buffered
interface alu_issue_if #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned OP_W          = 8
);
    logic                     flush_i;

    logic                     req0_valid_i;
    logic                     req0_ready_o;
    logic [OP_W-1:0]          req0_op_i;
    logic [XLEN-1:0]          req0_a_i;
    logic [XLEN-1:0]          req0_b_i;
    logic [TRANS_ID_BITS-1:0] req0_tid_i;

    logic                     req1_valid_i;
    logic                     req1_ready_o;
    logic [OP_W-1:0]          req1_op_i;
    logic [XLEN-1:0]          req1_a_i;
    logic [XLEN-1:0]          req1_b_i;
    logic [TRANS_ID_BITS-1:0] req1_tid_i;

    logic [OP_W-1:0]          alu_op_o;
    logic [XLEN-1:0]          alu_a_o;
    logic [XLEN-1:0]          alu_b_o;
    logic [XLEN-1:0]          alu_result_i;
    logic                     alu_branch_i;

    logic                     wb_valid_o;
    logic                     wb_ready_i;
    logic [XLEN-1:0]          wb_result_o;
    logic                     wb_branch_o;
    logic [TRANS_ID_BITS-1:0] wb_tid_o;
    logic                     wb_src_o;
    logic                     busy_o;

    modport slave (
        input  flush_i,
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_tid_i,
        output req0_ready_o,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_tid_i,
        output req1_ready_o,
        output alu_op_o, alu_a_o, alu_b_o,
        input  alu_result_i, alu_branch_i,
        output wb_valid_o, wb_result_o, wb_branch_o, wb_tid_o, wb_src_o,
        input  wb_ready_i,
        output busy_o
    );

    modport master (
        output flush_i,
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_tid_i,
        input  req0_ready_o,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_tid_i,
        input  req1_ready_o,
        input  alu_op_o, alu_a_o, alu_b_o,
        output alu_result_i, alu_branch_i,
        input  wb_valid_o, wb_result_o, wb_branch_o, wb_tid_o, wb_src_o,
        output wb_ready_i,
        input  busy_o
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Purpose: arbitrates two requesters onto a single-cycle-registered ALU, tracks the
// op in flight through the ALU output register and buffers results in an in-order
// FIFO until writeback accepts them.
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   bus      alu_issue_if slave: requests, ALU drive, writeback, flush, busy
module alu_issue_ctrl #(
    parameter int unsigned XLEN          = 64,
    parameter int unsigned TRANS_ID_BITS = 3,
    parameter int unsigned OP_W          = 8,
    parameter int unsigned NOP_OP        = 0,
    parameter int unsigned DEPTH         = 3,
    parameter int unsigned MAX_WAIT      = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    alu_issue_if.slave  bus
);
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned OCC_W  = CNT_W + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [XLEN-1:0]          result;
        logic                     branch;
        logic [TRANS_ID_BITS-1:0] tid;
        logic                     src;
    } entry_t;

    entry_t                   fifo_q [DEPTH];
    logic [PTR_W-1:0]         rd_ptr_q;
    logic [PTR_W-1:0]         wr_ptr_q;
    logic [CNT_W-1:0]         count_q;
    logic                     inflight_q;
    logic [TRANS_ID_BITS-1:0] inflight_tid_q;
    logic                     inflight_src_q;
    logic [WAIT_W-1:0]        wait_cnt_q;

    logic [OCC_W-1:0]         occupancy_c;
    logic                     can_issue_c;
    logic                     starve_c;
    logic                     grant0_c;
    logic                     grant1_c;
    logic                     head_valid_c;
    logic                     push_c;
    logic                     pop_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits count the inflight op as well, so the capture can never overflow the FIFO.
    assign occupancy_c  = OCC_W'(count_q) + OCC_W'(inflight_q);
    assign can_issue_c  = !bus.flush_i && (occupancy_c < OCC_W'(DEPTH));
    assign starve_c     = (wait_cnt_q == WAIT_W'(MAX_WAIT));
    assign grant1_c     = can_issue_c && bus.req1_valid_i && (!bus.req0_valid_i || starve_c);
    assign grant0_c     = can_issue_c && bus.req0_valid_i && !grant1_c;
    assign head_valid_c = (count_q != '0);
    assign push_c       = inflight_q;
    assign pop_c        = head_valid_c && bus.wb_ready_i;

    assign bus.req0_ready_o = grant0_c;
    assign bus.req1_ready_o = grant1_c;

    // ALU drive from the granted port; idle cycles issue a harmless NOP with zero operands.
    always_comb begin
        bus.alu_op_o = OP_W'(NOP_OP);
        bus.alu_a_o  = '0;
        bus.alu_b_o  = '0;
        if (grant1_c) begin
            bus.alu_op_o = bus.req1_op_i;
            bus.alu_a_o  = bus.req1_a_i;
            bus.alu_b_o  = bus.req1_b_i;
        end else if (grant0_c) begin
            bus.alu_op_o = bus.req0_op_i;
            bus.alu_a_o  = bus.req0_a_i;
            bus.alu_b_o  = bus.req0_b_i;
        end
    end

    // Writeback view of the FIFO head.
    assign bus.wb_valid_o  = head_valid_c;
    assign bus.wb_result_o = fifo_q[rd_ptr_q].result;
    assign bus.wb_branch_o = fifo_q[rd_ptr_q].branch;
    assign bus.wb_tid_o    = fifo_q[rd_ptr_q].tid;
    assign bus.wb_src_o    = fifo_q[rd_ptr_q].src;
    assign bus.busy_o      = inflight_q || head_valid_c;

    // Inflight tracking, result capture, FIFO pointers and starvation counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            inflight_q     <= 1'b0;
            inflight_tid_q <= '0;
            inflight_src_q <= 1'b0;
            wait_cnt_q     <= '0;
        end else if (bus.flush_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            inflight_q <= grant0_c || grant1_c;
            if (grant0_c || grant1_c) begin
                inflight_tid_q <= grant1_c ? bus.req1_tid_i : bus.req0_tid_i;
                inflight_src_q <= grant1_c;
            end
            if (push_c) begin
                fifo_q[wr_ptr_q] <= '{result: bus.alu_result_i, branch: bus.alu_branch_i,
                                      tid: inflight_tid_q, src: inflight_src_q};
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (grant1_c || !bus.req1_valid_i) begin
                wait_cnt_q <= '0;
            end else if (!starve_c) begin
                wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
        end
    end

    // The credit rule makes a capture into a full FIFO impossible.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     push_c |-> (count_q != CNT_W'(DEPTH)));

endmodule
